sfp_status_leds: RTL and testbench
==================================

// Module: sfp_status_leds
// PURPOSE
//  Status/LED stage on sysclk_100m: consumes per-SFP PCS block lock plus rx frame/error
//  toggle strobes from the 10G datapath and drives the 4 board LEDs (sleds) and link flags.
//  Debounces link, stretches activity into a visible blink, keeps sticky/counted errors.
// PARAMETERS
//  SFP_COUNT        2            number of SFP lanes, legal 1..2 (LED map below)
//  CLK_HZ           100_000_000  sysclk_100m frequency; CYC_MS = CLK_HZ/1000 (integer)
//  HEARTBEAT_MS     500          sleds[0] toggle period (half of blink period)
//  LOCK_DEBOUNCE_MS 10           continuous lock time before link declared up
//  ACT_STRETCH_MS   100          activity indication hold time after last frame
//  ACT_BLINK_MS     50           LED toggle interval while activity indication is held
// PORTS
//  sysclk_100m      in   1            system clock
//  sys_reset        in   1            synchronous, active-high reset
//  sfp_block_lock   in   SFP_COUNT    async level, PCS block lock per lane
//  sfp_rx_act_tgl   in   SFP_COUNT    async, toggles once per good rx frame
//  sfp_rx_err_tgl   in   SFP_COUNT    async, toggles once per rx error event
//  err_clear        in   1            1-cycle pulse, clears sticky errors and counters
//  sleds            out  4            [0] heartbeat, [1+i] lane i, [3] any error
//  link_up          out  SFP_COUNT    registered: lane FSM in LINK_UP
//  err_cnt          out  16*SFP_COUNT per-lane error count, lane i at [16*i+:16]
// BEHAVIOUR
//  Reset: all outputs 0, all counters 0, all FSMs LINK_DOWN, synchronizer flops 0.
//  Sync: every async input bit passes 2 flops (lock_s); toggles get a 3rd flop and
//   edge = s2^s3 -> 1-cycle pulse 3 cycles after input toggle. Toggle faster than
//   1 per 4 cycles is out of spec.
//  Lane FSM (per lane, 2-bit state):
//   LINK_DOWN: lock_s=1 -> LINK_WAIT, deb_cnt<=0.
//   LINK_WAIT: lock_s=0 -> LINK_DOWN; else deb_cnt++; deb_cnt==DEB_CYC-1 -> LINK_UP.
//     DEB_CYC = LOCK_DEBOUNCE_MS*CYC_MS. Up declared after DEB_CYC cycles of lock_s=1.
//   LINK_UP:   lock_s=0 -> LINK_DOWN same cycle (no debounce on loss); act state cleared.
//   link_up[i] registered from state, 1 cycle after the transition.
//  Activity (LINK_UP only): act pulse loads act_cnt=ACT_CYC-1 (retrigger reloads);
//   act_cnt decrements to 0 and holds. Act pulses outside LINK_UP ignored.
//  Blink base: shared free-running counter, blink_ph toggles every ACT_BLINK_MS*CYC_MS
//   cycles from reset.
//  Lane LED sleds[1+i]: LINK_DOWN/WAIT=0; LINK_UP & act_cnt==0 -> 1; LINK_UP &
//   act_cnt!=0 -> blink_ph. Unused lane LED (SFP_COUNT=1: sleds[2]) tied 0.
//  Heartbeat: counter 0..HB_CYC-1 (HB_CYC=HEARTBEAT_MS*CYC_MS); sleds[0] toggles on wrap.
//  Errors (any FSM state): err pulse sets err_sticky[i] and increments err_cnt[i],
//   saturating at 16'hFFFF. err_clear zeroes sticky+count; same-cycle err pulse wins:
//   sticky=1, count=1. sleds[3] = |err_sticky, registered.
//  All LED/flag outputs registered; no combinational input-to-output path.
// TESTING (CLK_HZ=10_000 -> CYC_MS=10; DEB=100, HB=5000, ACT=1000, BLINK=500 cycles)
//  1 Reset release, all inputs 0 -> sleds=4'b0000, link_up=0; sleds[0] rises @5000,
//    falls @10000 cycles.
//  2 lock[0] high -> link_up[0]=1 and sleds[1]=1 ~103 cycles later (2 sync+100
//    deb+1 reg). Repeat with a lock glitch low at cycle 60 -> stays down; count restarts.
//  3 Link up, one rx_act_tgl[0] toggle -> sleds[1] follows blink_ph for 1000 cycles,
//    then steady 1. Toggle every 200 cycles -> blink never ends.
//  4 Drop lock[0] while active -> link_up[0]=0, sleds[1]=0 within 4 cycles;
//    act toggles while down leave the LED off.
//  5 Three rx_err_tgl[1] toggles -> err_cnt[1]=3, sleds[3]=1. err_clear -> 0/0.
//    err_clear same cycle as an error pulse -> err_cnt=1, sleds[3]=1.
//  6 Force err_cnt[0]=16'hFFFE, two errors -> 16'hFFFF held. Assert sys_reset
//    mid-WAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/sfp_status_leds.sv
// Board status LEDs and link flags for up to two SFP lanes: synchronises PCS lock and
// rx activity/error toggles, debounces link, stretches activity into a blink, counts errors.
module sfp_status_leds #(
  parameter int SFP_COUNT        = 2,
  parameter int CLK_HZ           = 100_000_000,
  parameter int HEARTBEAT_MS     = 500,
  parameter int LOCK_DEBOUNCE_MS = 10,
  parameter int ACT_STRETCH_MS   = 100,
  parameter int ACT_BLINK_MS     = 50
) (
  input  logic                   sysclk_100m,
  input  logic                   sys_reset,
  input  logic [SFP_COUNT-1:0]   sfp_block_lock,
  input  logic [SFP_COUNT-1:0]   sfp_rx_act_tgl,
  input  logic [SFP_COUNT-1:0]   sfp_rx_err_tgl,
  input  logic                   err_clear,
  output logic [3:0]             sleds,
  output logic [SFP_COUNT-1:0]   link_up,
  output logic [16*SFP_COUNT-1:0] err_cnt
);

  localparam int CYC_MS    = CLK_HZ / 1000;
  localparam int DEB_CYC   = LOCK_DEBOUNCE_MS * CYC_MS;
  localparam int HB_CYC    = HEARTBEAT_MS * CYC_MS;
  localparam int ACT_CYC   = ACT_STRETCH_MS * CYC_MS;
  localparam int BLINK_CYC = ACT_BLINK_MS * CYC_MS;

  localparam int DEB_W   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int HB_W    = (HB_CYC > 1) ? $clog2(HB_CYC) : 1;
  localparam int ACT_W   = (ACT_CYC > 1) ? $clog2(ACT_CYC) : 1;
  localparam int BLINK_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  typedef enum logic [1:0] {
    LINK_DOWN = 2'd0,
    LINK_WAIT = 2'd1,
    LINK_UP   = 2'd2
  } link_state_e;

  logic [HB_W-1:0]    hb_cnt_q, hb_cnt_d;
  logic               hb_q, hb_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_ph_q, blink_ph_d;
  logic               err_led_q, err_led_d;

  logic [SFP_COUNT-1:0] lane_led;
  logic [SFP_COUNT-1:0] err_sticky;
  logic [1:0]           lane_led_ext;

  // Heartbeat and the shared blink phase are free-running timebases started at reset.
  always_comb begin
    hb_cnt_d    = hb_cnt_q + HB_W'(1);
    hb_d        = hb_q;
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    blink_ph_d  = blink_ph_q;
    if (hb_cnt_q == HB_W'(HB_CYC - 1)) begin
      hb_cnt_d = '0;
      hb_d     = ~hb_q;
    end
    if (blink_cnt_q == BLINK_W'(BLINK_CYC - 1)) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end
  end

  always_ff @(posedge sysclk_100m) begin
    if (sys_reset) begin
      hb_cnt_q    <= '0;
      hb_q        <= 1'b0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      err_led_q   <= 1'b0;
    end else begin
      hb_cnt_q    <= hb_cnt_d;
      hb_q        <= hb_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      err_led_q   <= err_led_d;
    end
  end

  for (genvar i = 0; i < SFP_COUNT; i++) begin : g_lane
    logic [1:0]       lock_sync_q, lock_sync_d;
    logic [2:0]       act_sync_q, act_sync_d;
    logic [2:0]       err_sync_q, err_sync_d;
    link_state_e      state_q, state_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [ACT_W-1:0] act_cnt_q, act_cnt_d;
    logic             link_up_q, link_up_d;
    logic             led_q, led_d;
    logic             err_sticky_q, err_sticky_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic             lock_s;
    logic             act_pulse;
    logic             err_pulse;

    // Toggle strobes get a third flop so a change between stages 2 and 3 is one pulse.
    always_comb begin
      lock_sync_d = {lock_sync_q[0], sfp_block_lock[i]};
      act_sync_d  = {act_sync_q[1:0], sfp_rx_act_tgl[i]};
      err_sync_d  = {err_sync_q[1:0], sfp_rx_err_tgl[i]};
      lock_s      = lock_sync_q[1];
      act_pulse   = act_sync_q[1] ^ act_sync_q[2];
      err_pulse   = err_sync_q[1] ^ err_sync_q[2];
    end

    always_comb begin
      state_d   = state_q;
      deb_cnt_d = deb_cnt_q;
      act_cnt_d = act_cnt_q;
      case (state_q)
        LINK_DOWN: begin
          act_cnt_d = '0;
          if (lock_s) begin
            state_d   = LINK_WAIT;
            deb_cnt_d = '0;
          end
        end
        LINK_WAIT: begin
          act_cnt_d = '0;
          if (!lock_s) begin
            state_d = LINK_DOWN;
          end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
            if (deb_cnt_q == DEB_W'(DEB_CYC - 1)) state_d = LINK_UP;
          end
        end
        LINK_UP: begin
          // Loss of lock drops the link immediately; only link-up is debounced.
          if (!lock_s) begin
            state_d   = LINK_DOWN;
            act_cnt_d = '0;
          end else if (act_pulse) begin
            act_cnt_d = ACT_W'(ACT_CYC - 1);
          end else if (act_cnt_q != '0) begin
            act_cnt_d = act_cnt_q - ACT_W'(1);
          end
        end
        default: begin
          state_d   = LINK_DOWN;
          act_cnt_d = '0;
        end
      endcase
    end

    always_comb begin
      link_up_d = (state_q == LINK_UP);
      led_d     = 1'b0;
      if (state_q == LINK_UP) led_d = (act_cnt_q == '0) ? 1'b1 : blink_ph_q;
    end

    // A clear and an error in the same cycle leave exactly that one error recorded.
    always_comb begin
      err_sticky_d = err_sticky_q;
      err_cnt_d    = err_cnt_q;
      if (err_clear) begin
        err_sticky_d = 1'b0;
        err_cnt_d    = '0;
      end
      if (err_pulse) begin
        err_sticky_d = 1'b1;
        if (err_cnt_d != 16'hFFFF) err_cnt_d = err_cnt_d + 16'd1;
      end
    end

    always_ff @(posedge sysclk_100m) begin
      if (sys_reset) begin
        lock_sync_q  <= '0;
        act_sync_q   <= '0;
        err_sync_q   <= '0;
        state_q      <= LINK_DOWN;
        deb_cnt_q    <= '0;
        act_cnt_q    <= '0;
        link_up_q    <= 1'b0;
        led_q        <= 1'b0;
        err_sticky_q <= 1'b0;
        err_cnt_q    <= '0;
      end else begin
        lock_sync_q  <= lock_sync_d;
        act_sync_q   <= act_sync_d;
        err_sync_q   <= err_sync_d;
        state_q      <= state_d;
        deb_cnt_q    <= deb_cnt_d;
        act_cnt_q    <= act_cnt_d;
        link_up_q    <= link_up_d;
        led_q        <= led_d;
        err_sticky_q <= err_sticky_d;
        err_cnt_q    <= err_cnt_d;
      end
    end

    assign link_up[i]           = link_up_q;
    assign lane_led[i]          = led_q;
    assign err_sticky[i]        = err_sticky_q;
    assign err_cnt[16*i +: 16]  = err_cnt_q;
  end

  always_comb begin
    lane_led_ext                 = '0;
    lane_led_ext[SFP_COUNT-1:0]  = lane_led;
    err_led_d                    = |err_sticky;
  end

  assign sleds = {err_led_q, lane_led_ext[1], lane_led_ext[0], hb_q};

endmodule

// File: tb/tb_sfp_status_leds.sv
// Self-checking bench for sfp_status_leds at CLK_HZ=10_000 (100-cycle debounce, 5000-cycle
// heartbeat, 1000-cycle activity stretch, 500-cycle blink) using an expected-value queue.
module tb_sfp_status_leds;

   localparam int SFP_COUNT = 2;
   localparam int DEB_CYC   = 100;
   localparam int HB_CYC    = 5000;
   localparam int ACT_CYC   = 1000;
   localparam int BLINK_CYC = 500;

   localparam int SEL_SLEDS  = 0;
   localparam int SEL_HB     = 1;
   localparam int SEL_L0     = 2;
   localparam int SEL_L1     = 3;
   localparam int SEL_ERRLED = 4;
   localparam int SEL_LINK   = 5;
   localparam int SEL_ERR0   = 6;
   localparam int SEL_ERR1   = 7;

   localparam int K_LOCK = 0;
   localparam int K_ACT  = 1;
   localparam int K_ERR  = 2;
   localparam int K_CLR  = 3;
   localparam int K_RST  = 4;

   logic                    sysClk = 1'b0;
   logic                    sysReset;
   logic [SFP_COUNT-1:0]    blockLock;
   logic [SFP_COUNT-1:0]    actTgl;
   logic [SFP_COUNT-1:0]    errTgl;
   logic                    errClear;
   logic [3:0]              sleds;
   logic [SFP_COUNT-1:0]    linkUp;
   logic [16*SFP_COUNT-1:0] errCnt;

   int vecCount  = 0;
   int missCount = 0;
   int cyc       = 0;
   int loadEdge  = -100000;
   int lat;
   int t0;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } expT;

   expT expQ[$];

   sfp_status_leds #(
      .SFP_COUNT(SFP_COUNT),
      .CLK_HZ(10_000),
      .HEARTBEAT_MS(500),
      .LOCK_DEBOUNCE_MS(10),
      .ACT_STRETCH_MS(100),
      .ACT_BLINK_MS(50)
   ) dut (
      .sysclk_100m(sysClk),
      .sys_reset(sysReset),
      .sfp_block_lock(blockLock),
      .sfp_rx_act_tgl(actTgl),
      .sfp_rx_err_tgl(errTgl),
      .err_clear(errClear),
      .sleds(sleds),
      .link_up(linkUp),
      .err_cnt(errCnt)
   );

   // 10-unit clock period
   always #5 sysClk = ~sysClk;

   // Reference cycle count: number of rising edges since reset was released
   always @(posedge sysClk) begin
      if (sysReset) cyc <= 0;
      else cyc <= cyc + 1;
   end

   // Hard stop in case something never returns
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare one observed value with its expected value and tally the result
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vecCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   // Drive one kind of stimulus; toggles flip the selected lane's strobe
   task automatic applyStimulus(input int kind, input int lane, input logic val);
      case (kind)
         K_LOCK:  blockLock[lane] = val;
         K_ACT:   actTgl[lane] = ~actTgl[lane];
         K_ERR:   errTgl[lane] = ~errTgl[lane];
         K_CLR:   errClear = val;
         default: sysReset = val;
      endcase
   endtask

   // Advance n clocks; inputs are driven and outputs sampled on the falling edge
   task automatic tick(input int n);
      repeat (n) @(negedge sysClk);
   endtask

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         SEL_SLEDS:  observe = {28'd0, sleds};
         SEL_HB:     observe = {31'd0, sleds[0]};
         SEL_L0:     observe = {31'd0, sleds[1]};
         SEL_L1:     observe = {31'd0, sleds[2]};
         SEL_ERRLED: observe = {31'd0, sleds[3]};
         SEL_LINK:   observe = {30'd0, linkUp};
         SEL_ERR0:   observe = {16'd0, errCnt[15:0]};
         SEL_ERR1:   observe = {16'd0, errCnt[31:16]};
         default:    observe = 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic pushExp(input string tag, input int sel, input logic [31:0] exp);
      expT e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      expQ.push_back(e);
   endtask

   // Pop every pending expectation and compare against the outputs as they are now
   task automatic drainCheck();
      expT e;
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput(e.tag, observe(e.sel), e.exp);
      end
   endtask

   // Lane 0 LED model while linked up: blink phase of the previous cycle during the stretch
   function automatic logic [31:0] expLane0(input int n, input int load);
      if (n <= load + ACT_CYC - 1) expLane0 = ((n - 1) / BLINK_CYC) % 2;
      else expLane0 = 1;
   endfunction

   // Wait (bounded) for lane 0 to report link up after a fixed pre-wait already spent
   task automatic waitLinkUp(input string tag, input int preWait);
      int got;
      lat = 0;
      while (!linkUp[0] && lat < 40) begin
         tick(1);
         lat++;
      end
      got = preWait + lat;
      $display("[TB] %s: link up after %0d cycles", tag, got);
      checkOutput(tag, {31'd0, (linkUp[0] === 1'b1) && got >= DEB_CYC + 1 && got <= DEB_CYC + 6}, 32'd1);
   endtask

   // Main sequence
   initial begin
      sysReset  = 1'b1;
      blockLock = '0;
      actTgl    = '0;
      errTgl    = '0;
      errClear  = 1'b0;
      tick(3);
      pushExp("rstSleds", SEL_SLEDS, 0);
      pushExp("rstLink", SEL_LINK, 0);
      pushExp("rstErr0", SEL_ERR0, 0);
      pushExp("rstErr1", SEL_ERR1, 0);
      drainCheck();

      // Heartbeat edges after reset release
      applyStimulus(K_RST, 0, 1'b0);
      tick(HB_CYC - 1);
      pushExp("hbLow", SEL_SLEDS, 0);
      drainCheck();
      tick(1);
      pushExp("hbRise", SEL_SLEDS, 1);
      drainCheck();
      tick(HB_CYC - 1);
      pushExp("hbHold", SEL_HB, 1);
      drainCheck();
      tick(1);
      pushExp("hbFall", SEL_HB, 0);
      drainCheck();

      // Lock with a glitch at cycle 60, so debounce must restart from the recovery
      applyStimulus(K_LOCK, 0, 1'b1);
      tick(60);
      applyStimulus(K_LOCK, 0, 1'b0);
      tick(1);
      applyStimulus(K_LOCK, 0, 1'b1);
      tick(DEB_CYC);
      pushExp("glitchHold", SEL_LINK, 0);
      pushExp("glitchLed", SEL_L0, 0);
      drainCheck();
      waitLinkUp("linkLat", DEB_CYC);
      pushExp("upLink", SEL_LINK, 1);
      pushExp("upLed", SEL_L0, 1);
      pushExp("lane1Off", SEL_L1, 0);
      drainCheck();

      // Single activity toggle: blink for the stretch time, then steady
      tick(20);
      t0 = cyc;
      applyStimulus(K_ACT, 0, 1'b0);
      loadEdge = t0 + 3;
      tick(4);
      for (int k = 0; k < 11; k++) begin
         pushExp("actBlink", SEL_L0, expLane0(cyc, loadEdge));
         drainCheck();
         tick(97);
      end
      tick(20);
      pushExp("actSteady", SEL_L0, 1);
      drainCheck();

      // Retrigger every 200 cycles keeps the blink going
      for (int k = 0; k < 10; k++) begin
         applyStimulus(K_ACT, 0, 1'b0);
         loadEdge = cyc + 3;
         tick(150);
         pushExp("actRetrig", SEL_L0, expLane0(cyc, loadEdge));
         drainCheck();
         tick(50);
      end

      // Drop lock while active, then activity while down must not light the LED
      applyStimulus(K_LOCK, 0, 1'b0);
      tick(4);
      pushExp("dropLink", SEL_LINK, 0);
      pushExp("dropLed", SEL_L0, 0);
      drainCheck();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(K_ACT, 0, 1'b0);
         tick(10);
         pushExp("actWhileDown", SEL_L0, 0);
         drainCheck();
      end
      applyStimulus(K_LOCK, 0, 1'b1);
      tick(DEB_CYC);
      waitLinkUp("relinkLat", DEB_CYC);
      pushExp("relinkLed", SEL_L0, 1);
      drainCheck();
      tick(BLINK_CYC);
      pushExp("relinkLedLater", SEL_L0, 1);
      drainCheck();

      // Lane 1 errors: count, clear, and clear colliding with an error
      for (int k = 0; k < 3; k++) begin
         applyStimulus(K_ERR, 1, 1'b0);
         tick(6);
      end
      pushExp("err1Three", SEL_ERR1, 3);
      pushExp("errLedOn", SEL_ERRLED, 1);
      pushExp("err0Quiet", SEL_ERR0, 0);
      drainCheck();
      applyStimulus(K_CLR, 0, 1'b1);
      tick(1);
      applyStimulus(K_CLR, 0, 1'b0);
      tick(2);
      pushExp("err1Clr", SEL_ERR1, 0);
      pushExp("errLedClr", SEL_ERRLED, 0);
      drainCheck();
      for (int k = 0; k < 2; k++) begin
         applyStimulus(K_ERR, 1, 1'b0);
         tick(6);
      end
      pushExp("err1Two", SEL_ERR1, 2);
      drainCheck();
      applyStimulus(K_ERR, 1, 1'b0);
      tick(2);
      applyStimulus(K_CLR, 0, 1'b1);
      tick(1);
      applyStimulus(K_CLR, 0, 1'b0);
      tick(3);
      pushExp("clrCollide", SEL_ERR1, 1);
      pushExp("clrCollideLed", SEL_ERRLED, 1);
      drainCheck();

      // Lane 0 counter saturation from a preloaded near-full value
      force dut.g_lane[0].err_cnt_q = 16'hFFFE;
      tick(2);
      release dut.g_lane[0].err_cnt_q;
      tick(1);
      pushExp("err0Preload", SEL_ERR0, 32'hFFFE);
      drainCheck();
      applyStimulus(K_ERR, 0, 1'b0);
      tick(6);
      pushExp("err0Full", SEL_ERR0, 32'hFFFF);
      drainCheck();
      applyStimulus(K_ERR, 0, 1'b0);
      tick(6);
      pushExp("err0Sat", SEL_ERR0, 32'hFFFF);
      pushExp("err1Kept", SEL_ERR1, 1);
      drainCheck();

      // Reset in the middle of lane 1 debounce clears every output
      applyStimulus(K_LOCK, 1, 1'b1);
      tick(50);
      applyStimulus(K_RST, 0, 1'b1);
      tick(1);
      pushExp("midRstSleds", SEL_SLEDS, 0);
      pushExp("midRstLink", SEL_LINK, 0);
      pushExp("midRstErr0", SEL_ERR0, 0);
      pushExp("midRstErr1", SEL_ERR1, 0);
      drainCheck();
      applyStimulus(K_RST, 0, 1'b0);
      tick(60);
      pushExp("postRstLink", SEL_LINK, 0);
      drainCheck();

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
